// File: rtl/sm_regdump.sv
// sm_regdump
//   Debug-side register dumper. A start pulse walks the CPU debug address
//   port from FIRST_REG to LAST_REG, captures each 32-bit word and sends it
//   out on an 8N1 UART line, most significant byte first.
//
//   Optional build macro: SM_REGDUMP_HEX_EN
//     defined   -> each word goes out as 8 upper-case ASCII hex digits + CR LF
//     undefined -> each word goes out as 4 raw binary bytes
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   start    in   one-cycle dump request (accepted only when idle)
//   regAddr  out  debug register address to the CPU (registered)
//   regData  in   debug register data from the CPU
//   uart_tx  out  serial output, idles high
//   busy     out  high while a dump is in progress
//   done     out  one-cycle pulse after the last stop bit
//
// state     | meaning
// S_IDLE    | line idle, waiting for start
// S_SETADDR | regAddr presented, CPU read path settling
// S_CAPTURE | regData latched into the shift word
// S_SEND    | serialising the bytes of the current word
// S_FIN     | done pulse, then back to idle
module sm_regdump #(
    parameter int CLK_DIV   = 434,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

`ifdef SM_REGDUMP_HEX_EN
    localparam int BYTE_W = 4;
    localparam logic [BYTE_W-1:0] BYTE_LAST = 4'd9;
    localparam int SHIFT = 4;
`else
    localparam int BYTE_W = 2;
    localparam logic [BYTE_W-1:0] BYTE_LAST = 2'd3;
    localparam int SHIFT = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETADDR,
        S_CAPTURE,
        S_SEND,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [7:0]        cur_byte;
    logic              tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

`ifdef SM_REGDUMP_HEX_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // The word shifts left one nibble per digit, so the digit to send is
    // always the top nibble; the last two byte slots carry CR and LF.
    always_comb begin
        cur_byte = hex_ascii(word_q[31:28]);
        if (byte_q == 4'd8) begin
            cur_byte = 8'h0D;
        end else if (byte_q == 4'd9) begin
            cur_byte = 8'h0A;
        end
    end
`else
    assign cur_byte = word_q[31:24];
`endif

    // Frame position 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_q == 4'd0) begin
            tx_bit = 1'b0;
        end else if (bit_q <= 4'd8) begin
            tx_bit = cur_byte[3'(bit_q - 4'd1)];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = 5'(FIRST_REG);
                    state_d = S_SETADDR;
                end
            end
            S_SETADDR: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                word_d  = regData;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d  = '0;
                        word_d = word_q << SHIFT;
                        if (byte_q == BYTE_LAST) begin
                            if (addr_q == 5'(LAST_REG)) begin
                                state_d = S_FIN;
                            end else begin
                                addr_d  = addr_q + 5'd1;
                                state_d = S_SETADDR;
                            end
                        end else begin
                            byte_d = byte_q + BYTE_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers so reset forces the line high at once.
    assign regAddr = addr_q;
    assign uart_tx = (state_q == S_SEND) ? tx_bit : 1'b1;
    assign busy    = (state_q == S_SETADDR) || (state_q == S_CAPTURE) || (state_q == S_SEND);
    assign done    = (state_q == S_FIN);

endmodule

// File: tb/tb_sm_regdump.sv
// Testbench for sm_regdump: one single-register instance and one full-range
// instance, each watched by a mid-bit UART receiver that checks received
// bytes against a queue of expected bytes.
module tb_sm_regdump;

    localparam int D = 4;
`ifdef SM_REGDUMP_HEX_EN
    localparam int          BPW      = 10;
    localparam int          SGL_REG  = 3;
    localparam logic [31:0] SGL_WORD = 32'hDEAD_BEEF;
`else
    localparam int          BPW      = 4;
    localparam int          SGL_REG  = 0;
    localparam logic [31:0] SGL_WORD = 32'h0000_0010;
`endif
    localparam int WORD_CYC = BPW * 10 * D + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s = 1'b0, start_f = 1'b0;
    logic [4:0]  regAddr_s, regAddr_f;
    logic [31:0] regData_s, regData_f;
    logic        tx_s, tx_f, busy_s, busy_f, done_s, done_f;
    logic        noise = 1'b0;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt[2] = '{0, 0};
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (done_s) done_cnt[0] <= done_cnt[0] + 1;
        if (done_f) done_cnt[1] <= done_cnt[1] + 1;
    end

    function automatic logic [31:0] noise_word(input int unsigned c);
        return {c[15:0], ~c[15:0]} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [31:0] full_word(input int a);
        logic [31:0] w;
        w = 32'(a);
        return w ^ 32'hA5A5_0000;
    endfunction

    assign regData_s = noise ? noise_word(cyc) : SGL_WORD;
    assign regData_f = {27'h0, regAddr_f} ^ 32'hA5A5_0000;

    sm_regdump #(.CLK_DIV(D), .FIRST_REG(SGL_REG), .LAST_REG(SGL_REG)) u_single (
        .clk(clk), .rst_n(rst_n), .start(start_s), .regAddr(regAddr_s),
        .regData(regData_s), .uart_tx(tx_s), .busy(busy_s), .done(done_s));

    sm_regdump #(.CLK_DIV(D), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start_f), .regAddr(regAddr_f),
        .regData(regData_f), .uart_tx(tx_f), .busy(busy_f), .done(done_f));

    function automatic logic get_tx(input int g);   return (g == 0) ? tx_s : tx_f;     endfunction
    function automatic logic get_busy(input int g); return (g == 0) ? busy_s : busy_f; endfunction
    function automatic logic get_done(input int g); return (g == 0) ? done_s : done_f; endfunction

    task automatic set_start(input int g, input logic v);
        if (g == 0) start_s = v; else start_f = v;
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int b);
`ifdef SM_REGDUMP_HEX_EN
        string digits;
        logic [3:0] n;
        digits = "0123456789ABCDEF";
        if (b == 8) return 8'h0D;
        if (b == 9) return 8'h0A;
        n = w[31 - 4 * b -: 4];
        return digits[n];
`else
        return 8'(w >> (24 - 8 * b));
`endif
    endfunction

    function automatic void push_exp(input int g, input logic [7:0] v);
        if (g == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    endfunction

    function automatic int exp_size(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void push_word(input int g, input logic [31:0] w);
        for (int b = 0; b < BPW; b++) push_exp(g, get_byte(w, b));
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called on the first negedge where the start bit is seen; samples each bit near its middle.
    task automatic rx_byte(input int g, output logic [7:0] b, output logic ab, output logic fok);
        ab = 1'b0; fok = 1'b1; b = '0;
        repeat (D / 2 - 1) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
        if (get_tx(g) !== 1'b0) fok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (D) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            b[i] = get_tx(g);
        end
        repeat (D) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
        if (get_tx(g) !== 1'b1) fok = 1'b0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        always begin : rx
            logic [7:0] b;
            logic [7:0] e;
            logic ab, fok;
            @(negedge clk);
            if (rst_n && get_tx(g) === 1'b0) begin
                rx_byte(g, b, ab, fok);
                if (!ab) begin
                    n_tests++;
                    if (exp_size(g) == 0) begin
                        n_fail++;
                        $display("FAIL rx%0d_unexpected: got byte %02h, none expected", g, b);
                    end else begin
                        e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (b !== e || !fok) begin
                            n_fail++;
                            $display("FAIL rx%0d_byte: got %02h (framing ok=%0b) expected %02h", g, b, fok, e);
                        end
                    end
                end
            end
        end
    end

    // Starts a dump, measures start-to-done latency and busy-high cycles.
    // repulse: cycle index (0 = start cycle) in which start is raised again.
    // chain: return right at the done cycle so a follow-up start lands in the next cycle.
    task automatic dump(input int g, input int nwords, input int repulse,
                        input bit with_noise, input bit chain, input string nm);
        int lat, busy_n;
        lat = -1; busy_n = 0;
        @(posedge clk); #1;
        set_start(g, 1'b1);
        if (with_noise) push_word(g, noise_word(cyc + 2));
        for (int k = 0; k < nwords * WORD_CYC + 50; k++) begin
            @(negedge clk);
            if (get_busy(g)) busy_n++;
            if (get_done(g)) begin lat = k; break; end
            @(posedge clk); #1;
            set_start(g, (k + 1) == repulse);
        end
        check({nm, "_done_latency"}, lat, nwords * WORD_CYC + 1);
        check({nm, "_busy_cycles"}, busy_n, nwords * WORD_CYC);
        if (chain) return;
        @(posedge clk); #1;
        set_start(g, 1'b0);
        @(negedge clk); #1;
        check({nm, "_done_one_cycle"}, get_done(g), 0);
        check({nm, "_busy_after"}, get_busy(g), 0);
        check({nm, "_bytes_left"}, exp_size(g), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d0, r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_s", tx_s, 1);
        check("reset_tx_f", tx_f, 1);
        check("reset_busy", {busy_s, busy_f}, 0);
        check("reset_done", {done_s, done_f}, 0);
        check("reset_addr_s", regAddr_s, 0);
        check("reset_addr_f", regAddr_f, 0);
        rst_n = 1'b1;

        // Single word; start in the FIN cycle is ignored, start right after is taken.
        d0 = done_cnt[0];
        push_word(0, SGL_WORD);
        dump(0, 1, WORD_CYC + 1, 1'b0, 1'b1, "single_a");
        push_word(0, SGL_WORD);
        dump(0, 1, -1, 1'b0, 1'b0, "single_b");
        check("single_done_count", done_cnt[0] - d0, 2);
        check("single_addr_hold", regAddr_s, SGL_REG);

        // regData changing every cycle: only the CAPTURE-cycle value is sent.
        noise = 1'b1;
        dump(0, 1, -1, 1'b1, 1'b0, "noise");
        noise = 1'b0;
        check("noise_done_count", done_cnt[0] - d0, 3);

        // Reset in the middle of byte 1 of word 2.
        d0 = done_cnt[1];
        push_word(1, full_word(0));
        push_word(1, full_word(1));
        push_exp(1, get_byte(full_word(2), 0));
        r = 3 + 2 * WORD_CYC + 10 * D + 5 * D - 1;
        @(posedge clk); #1; start_f = 1'b1;
        @(posedge clk); #1; start_f = 1'b0;
        repeat (r - 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_f, 1);
        check("rst_mid_busy", busy_f, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (WORD_CYC) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt[1] - d0, 0);
        check("rst_mid_bytes_left", exp_size(1), 0);
        check("rst_mid_addr", regAddr_f, 0);

        // Full clean dump after the reset.
        for (int a = 0; a < 32; a++) push_word(1, full_word(a));
        dump(1, 32, -1, 1'b0, 1'b0, "full");
        check("full_done_count", done_cnt[1] - d0, 1);
        check("full_addr_hold", regAddr_f, 31);

        // start re-pulsed during word 5 changes nothing.
        for (int a = 0; a < 32; a++) push_word(1, full_word(a));
        dump(1, 32, 3 + 5 * WORD_CYC + 7, 1'b0, 1'b0, "repulse");
        check("repulse_done_count", done_cnt[1] - d0, 2);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
